end_game_overlay: RTL and testbench

- Parametrised end-of-round overlay controller for the VGA path; sits in the object mux above the maze layers.
- Detects round outcome (level cleared, game won, game lost) and freezes gameplay.
- Reveals a grey maze-wide panel with a top-down wipe, then shows blinking outcome text.
- Handles continue/restart through a request pulse to the game controller.
- Supports multi-level play and an optional auto-continue timeout.

---
 rtl/overlay_pkg.sv | 54 +++++
 rtl/end_game_fsm.sv | 181 ++++++++++++++++++
 rtl/text_gen.sv | 56 +++++
 rtl/end_game_overlay.sv | 117 +++++++++++
 tb/tb_end_game_overlay.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/overlay_pkg.sv
// overlay_pkg: shared types, colours, tile size and 8x8 glyph table for the
// end-of-round overlay.
`default_nettype none

package overlay_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LEVEL_UP = 2'd1,
        WON      = 2'd2,
        LOST     = 2'd3
    } outcome_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_WIPE = 3'd2,
        S_SHOW = 3'd3,
        S_EXIT = 3'd4
    } state_t;

    localparam int         TILE_SIZE  = 16;
    localparam logic [7:0] COL_TRNS   = 8'hFF;
    localparam logic [7:0] COL_GREY   = 8'h92;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_GREEN  = 8'h1C;
    localparam logic [7:0] COL_RED    = 8'hE0;

    // Only the letters used by the outcome strings; row 0 is the top byte,
    // bit 7 is the leftmost column.
    function automatic logic [7:0] glyph_row(input logic [7:0] ch, input logic [2:0] row);
        logic [63:0] g;
        case (ch)
            "A":     g = 64'h183C66667E666600;
            "E":     g = 64'h7E60607C60607E00;
            "G":     g = 64'h3C66606E66663C00;
            "L":     g = 64'h6060606060607E00;
            "M":     g = 64'h63777F6B63636300;
            "N":     g = 64'h66767E7E6E666600;
            "O":     g = 64'h3C66666666663C00;
            "P":     g = 64'h7C66667C60606000;
            "S":     g = 64'h3C66603C06663C00;
            "T":     g = 64'h7E18181818181800;
            "U":     g = 64'h6666666666663C00;
            "V":     g = 64'h66666666663C1800;
            "W":     g = 64'h6363636B7F776300;
            default: g = 64'h0;
        endcase
        return g[{3'd7 - row, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/end_game_fsm.sv
// end_game_fsm: round-outcome detection, wipe/blink/hold counters and the
// one-clock continue/restart request pulses.
`default_nettype none

module end_game_fsm
    import overlay_pkg::*;
#(
    parameter int LEVELS          = 4,
    parameter int SCREEN_H        = 480,
    parameter int WIPE_STEP_PX    = 16,
    parameter int BLINK_FRAMES    = 30,
    parameter int MIN_HOLD_FRAMES = 60,
    parameter int AUTO_FRAMES     = 300
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      frame_start,
    input  logic                      game_started,
    input  logic                      pdot_exist,
    input  logic                      edot_exist,
    input  logic [2:0]                lives,
    input  logic [$clog2(LEVELS)-1:0] level,
    input  logic                      key_continue,
    output state_t                    state,
    output outcome_t                  outcome,
    output logic                      freeze_game,
    output logic                      next_level_req,
    output logic                      restart_req,
    output logic [10:0]               wipe_row,
    output logic                      text_on
);

    localparam int LW       = $clog2(LEVELS);
    localparam int HOLD_MAX = (AUTO_FRAMES > MIN_HOLD_FRAMES) ? AUTO_FRAMES : MIN_HOLD_FRAMES;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int BW       = $clog2(BLINK_FRAMES + 1);

    localparam logic [LW-1:0] LAST_LEVEL = LW'(LEVELS - 1);
    localparam logic [10:0]   SCREEN_H_W = 11'(SCREEN_H);
    localparam logic [HW-1:0] HOLD_MAX_W = HW'(HOLD_MAX);
    localparam logic [HW-1:0] MIN_HOLD_W = HW'(MIN_HOLD_FRAMES);
    localparam logic [HW-1:0] AUTO_LAST  = (AUTO_FRAMES > 0) ? HW'(AUTO_FRAMES - 1) : '0;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    state_t        state_n;
    outcome_t      outcome_n;
    logic          freeze_n;
    logic          next_level_n;
    logic          restart_n;
    logic [10:0]   wipe_n;
    logic          text_on_n;
    logic [BW-1:0] blink;
    logic [BW-1:0] blink_n;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_n;
    logic          go_idle;
    logic          dots_clear;
    logic          leave_show;
    logic [11:0]   wipe_sum;
    logic [10:0]   wipe_next;

    assign dots_clear = !pdot_exist && !edot_exist;
    assign wipe_sum   = {1'b0, wipe_row} + 12'(WIPE_STEP_PX);
    assign wipe_next  = (wipe_sum >= 12'(SCREEN_H)) ? SCREEN_H_W : wipe_sum[10:0];
    assign leave_show = (key_continue && (hold >= MIN_HOLD_W)) ||
                        ((AUTO_FRAMES != 0) && frame_start && (hold == AUTO_LAST));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= S_IDLE;
            outcome        <= NONE;
            freeze_game    <= 1'b0;
            next_level_req <= 1'b0;
            restart_req    <= 1'b0;
            wipe_row       <= '0;
            blink          <= '0;
            hold           <= '0;
            text_on        <= 1'b1;
        end else begin
            state          <= state_n;
            outcome        <= outcome_n;
            freeze_game    <= freeze_n;
            next_level_req <= next_level_n;
            restart_req    <= restart_n;
            wipe_row       <= wipe_n;
            blink          <= blink_n;
            hold           <= hold_n;
            text_on        <= text_on_n;
        end
    end

    always_comb begin
        state_n      = state;
        outcome_n    = outcome;
        freeze_n     = freeze_game;
        next_level_n = 1'b0;
        restart_n    = 1'b0;
        wipe_n       = wipe_row;
        blink_n      = blink;
        hold_n       = hold;
        text_on_n    = text_on;
        go_idle      = 1'b0;

        case (state)
            S_IDLE: begin
                if (game_started) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (!game_started) begin
                    go_idle = 1'b1;
                end else if (dots_clear || (lives == 3'd0)) begin
                    // A cleared board wins over a simultaneous last-life loss.
                    if (dots_clear) outcome_n = (level == LAST_LEVEL) ? WON : LEVEL_UP;
                    else            outcome_n = LOST;
                    freeze_n = 1'b1;
                    wipe_n   = '0;
                    state_n  = S_WIPE;
                end
            end
            S_WIPE: begin
                if (!game_started) begin
                    go_idle = 1'b1;
                end else if (wipe_row >= SCREEN_H_W) begin
                    state_n   = S_SHOW;
                    blink_n   = '0;
                    hold_n    = '0;
                    text_on_n = 1'b1;
                end else if (frame_start) begin
                    wipe_n = wipe_next;
                end
            end
            S_SHOW: begin
                if (!game_started) begin
                    go_idle = 1'b1;
                end else begin
                    if (frame_start) begin
                        hold_n = (hold == HOLD_MAX_W) ? hold : hold + 1'b1;
                        if (blink == BLINK_LAST) begin
                            blink_n   = '0;
                            text_on_n = !text_on;
                        end else begin
                            blink_n = blink + 1'b1;
                        end
                    end
                    if (leave_show) begin
                        next_level_n = (outcome == LEVEL_UP);
                        restart_n    = (outcome != LEVEL_UP);
                        state_n      = S_EXIT;
                    end
                end
            end
            S_EXIT: begin
                // Level-up waits for the controller to refill the maze;
                // game end waits for it to drop game_started.
                if (outcome == LEVEL_UP) begin
                    if (pdot_exist || edot_exist) begin
                        state_n   = S_PLAY;
                        outcome_n = NONE;
                        freeze_n  = 1'b0;
                    end
                end else if (!game_started) begin
                    go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_n   = S_IDLE;
            outcome_n = NONE;
            freeze_n  = 1'b0;
            wipe_n    = '0;
            blink_n   = '0;
            hold_n    = '0;
            text_on_n = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/text_gen.sv
// text_gen: draw request for a fixed string placed on a tile, glyphs scaled
// by 2^SCALING_EXP; combinational so the caller owns the output register.
`default_nettype none

module text_gen
    import overlay_pkg::*;
#(
    parameter int              TILE_X      = 10,
    parameter int              TILE_Y      = 14,
    parameter int              SCALING_EXP = 2,
    parameter int              BG_EN       = 0,
    parameter int              LEN         = 8,
    parameter logic [8*LEN-1:0] TEXT       = "LEVEL UP"
) (
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        dr
);

    localparam int          CHAR_W = 8 << SCALING_EXP;
    localparam logic [10:0] X0 = 11'(TILE_X * TILE_SIZE);
    localparam logic [10:0] Y0 = 11'(TILE_Y * TILE_SIZE);
    localparam logic [10:0] X1 = 11'(TILE_X * TILE_SIZE + LEN * CHAR_W);
    localparam logic [10:0] Y1 = 11'(TILE_Y * TILE_SIZE + CHAR_W);

    logic        in_box;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] char_idx;
    logic [2:0]  col;
    logic [2:0]  row;
    logic [7:0]  ch;
    logic [7:0]  bits;

    assign in_box   = (pixel_x >= X0) && (pixel_x < X1) && (pixel_y >= Y0) && (pixel_y < Y1);
    assign dx       = pixel_x - X0;
    assign dy       = pixel_y - Y0;
    assign char_idx = dx >> (3 + SCALING_EXP);
    assign col      = 3'(dx >> SCALING_EXP);
    assign row      = 3'(dy >> SCALING_EXP);

    always_comb begin
        ch = 8'h20;
        for (int i = 0; i < LEN; i++) begin
            if (char_idx == 11'(i)) begin
                ch = TEXT[8*(LEN-1-i) +: 8];
            end
        end
    end

    assign bits = glyph_row(ch, row);
    assign dr   = in_box && ((BG_EN != 0) || bits[3'd7 - col]);

endmodule

`default_nettype wire

// File: rtl/end_game_overlay.sv
// end_game_overlay: end-of-round grey panel with top-down wipe and blinking
// outcome text; drawn one clock after the pixel coordinates.
`default_nettype none

module end_game_overlay
    import overlay_pkg::*;
#(
    parameter int LEVELS          = 4,
    parameter int MAZE_X_MIN_TILE = 5,
    parameter int MAZE_X_MAX_TILE = 33,
    parameter int SCREEN_H        = 480,
    parameter int WIPE_STEP_PX    = 16,
    parameter int BLINK_FRAMES    = 30,
    parameter int MIN_HOLD_FRAMES = 60,
    parameter int AUTO_FRAMES     = 300
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [10:0]               pixel_x,
    input  logic [10:0]               pixel_y,
    input  logic                      frame_start,
    input  logic                      game_started,
    input  logic                      pdot_exist,
    input  logic                      edot_exist,
    input  logic [2:0]                lives,
    input  logic [$clog2(LEVELS)-1:0] level,
    input  logic                      key_continue,
    output logic                      dr_out,
    output logic [7:0]                RGB_out,
    output logic [1:0]                outcome,
    output logic                      freeze_game,
    output logic                      next_level_req,
    output logic                      restart_req
);

    localparam logic [10:0] X_LO = 11'(MAZE_X_MIN_TILE * TILE_SIZE);
    localparam logic [10:0] X_HI = 11'(MAZE_X_MAX_TILE * TILE_SIZE);

    state_t      state;
    outcome_t    fsm_outcome;
    logic [10:0] wipe_row;
    logic        text_on;
    logic        in_maze;
    logic        panel;
    logic        dr_lvl;
    logic        dr_won;
    logic        dr_lost;
    logic        txt_dr;
    logic [7:0]  txt_col;

    end_game_fsm #(
        .LEVELS          (LEVELS),
        .SCREEN_H        (SCREEN_H),
        .WIPE_STEP_PX    (WIPE_STEP_PX),
        .BLINK_FRAMES    (BLINK_FRAMES),
        .MIN_HOLD_FRAMES (MIN_HOLD_FRAMES),
        .AUTO_FRAMES     (AUTO_FRAMES)
    ) u_fsm (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .game_started   (game_started),
        .pdot_exist     (pdot_exist),
        .edot_exist     (edot_exist),
        .lives          (lives),
        .level          (level),
        .key_continue   (key_continue),
        .state          (state),
        .outcome        (fsm_outcome),
        .freeze_game    (freeze_game),
        .next_level_req (next_level_req),
        .restart_req    (restart_req),
        .wipe_row       (wipe_row),
        .text_on        (text_on)
    );

    assign outcome = fsm_outcome;

    text_gen #(.TILE_X(10), .TILE_Y(14), .SCALING_EXP(2), .BG_EN(0), .LEN(8), .TEXT("LEVEL UP"))
        u_txt_lvl (.pixel_x(pixel_x), .pixel_y(pixel_y), .dr(dr_lvl));

    text_gen #(.TILE_X(10), .TILE_Y(14), .SCALING_EXP(2), .BG_EN(0), .LEN(8), .TEXT("GAME WON"))
        u_txt_won (.pixel_x(pixel_x), .pixel_y(pixel_y), .dr(dr_won));

    text_gen #(.TILE_X(10), .TILE_Y(14), .SCALING_EXP(2), .BG_EN(0), .LEN(9), .TEXT("GAME LOST"))
        u_txt_lost (.pixel_x(pixel_x), .pixel_y(pixel_y), .dr(dr_lost));

    assign in_maze = (pixel_x > X_LO) && (pixel_x < X_HI);
    assign panel   = in_maze && (((state == S_WIPE) && (pixel_y < wipe_row)) ||
                                 (state == S_SHOW) || (state == S_EXIT));

    always_comb begin
        txt_dr  = 1'b0;
        txt_col = COL_GREY;
        case (fsm_outcome)
            LEVEL_UP: begin txt_dr = dr_lvl;  txt_col = COL_YELLOW; end
            WON:      begin txt_dr = dr_won;  txt_col = COL_GREEN;  end
            LOST:     begin txt_dr = dr_lost; txt_col = COL_RED;    end
            default:  begin txt_dr = 1'b0;    txt_col = COL_GREY;   end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dr_out  <= 1'b0;
            RGB_out <= COL_TRNS;
        end else begin
            dr_out <= panel;
            if (!panel)                  RGB_out <= COL_TRNS;
            else if (txt_dr && text_on)  RGB_out <= txt_col;
            else                         RGB_out <= COL_GREY;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_end_game_overlay.sv
// tb_end_game_overlay: directed scenarios for outcome detection, wipe,
// blinking text, continue/auto-continue, abort and asynchronous reset.
`default_nettype none

module tb_end_game_overlay;
    import overlay_pkg::*;

    localparam logic [7:0] E_TRNS  = 8'hFF;
    localparam logic [7:0] E_GREY  = 8'h92;
    localparam logic [7:0] E_GREEN = 8'h1C;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        frame_start;
    logic        game_started;
    logic        pdot_exist;
    logic        edot_exist;
    logic [2:0]  lives;
    logic [1:0]  level;
    logic        key_continue;
    logic        dr_out;
    logic [7:0]  RGB_out;
    logic [1:0]  outcome;
    logic        freeze_game;
    logic        next_level_req;
    logic        restart_req;

    int total  = 0;
    int bad    = 0;
    int nl_cnt = 0;
    int rs_cnt = 0;

    always #5 clk = ~clk;

    end_game_overlay dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .frame_start    (frame_start),
        .game_started   (game_started),
        .pdot_exist     (pdot_exist),
        .edot_exist     (edot_exist),
        .lives          (lives),
        .level          (level),
        .key_continue   (key_continue),
        .dr_out         (dr_out),
        .RGB_out        (RGB_out),
        .outcome        (outcome),
        .freeze_game    (freeze_game),
        .next_level_req (next_level_req),
        .restart_req    (restart_req)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (next_level_req) nl_cnt++;
        if (restart_req)    rs_cnt++;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic at(input int x, input int y);
        pixel_x = 11'(x);
        pixel_y = 11'(y);
        tick();
    endtask

    initial begin
        resetN = 1'b0; pixel_x = '0; pixel_y = '0; frame_start = 1'b0;
        game_started = 1'b0; pdot_exist = 1'b1; edot_exist = 1'b1;
        lives = 3'd3; level = 2'd0; key_continue = 1'b0;
        tick(); tick();
        check("rst_dr",      32'(dr_out),         32'(0));
        check("rst_rgb",     32'(RGB_out),        32'(E_TRNS));
        check("rst_outcome", 32'(outcome),        32'(0));
        check("rst_freeze",  32'(freeze_game),    32'(0));
        check("rst_nl",      32'(next_level_req), 32'(0));
        resetN = 1'b1;
        tick();

        // Level up on level 1 of 4
        level = 2'd1; game_started = 1'b1;
        tick();
        check("lu_play", 32'(dut.u_fsm.state), 32'(S_PLAY));
        pdot_exist = 1'b0; edot_exist = 1'b0;
        tick();
        check("lu_outcome", 32'(outcome),     32'(1));
        check("lu_freeze",  32'(freeze_game), 32'(1));
        frame();
        at(100, 10);
        check("wipe_dr_in",   32'(dr_out),  32'(1));
        check("wipe_rgb_in",  32'(RGB_out), 32'(E_GREY));
        at(100, 20);
        check("wipe_dr_out",  32'(dr_out),  32'(0));
        check("wipe_rgb_out", 32'(RGB_out), 32'(E_TRNS));
        frames(29);
        check("wipe_done", 32'(dut.u_fsm.state), 32'(S_SHOW));
        frames(59);
        key_continue = 1'b1; tick(); key_continue = 1'b0;
        check("key_early_nl",    32'(nl_cnt),           32'(0));
        check("key_early_state", 32'(dut.u_fsm.state),  32'(S_SHOW));
        frame();
        key_continue = 1'b1; tick(); key_continue = 1'b0;
        check("key_nl_hi", 32'(next_level_req), 32'(1));
        tick();
        check("key_nl_lo",  32'(next_level_req), 32'(0));
        check("key_nl_cnt", 32'(nl_cnt),         32'(1));
        check("exit_freeze", 32'(freeze_game),   32'(1));
        pdot_exist = 1'b1;
        tick();
        check("lu_back_play",   32'(dut.u_fsm.state), 32'(S_PLAY));
        check("lu_back_freeze", 32'(freeze_game),     32'(0));
        check("lu_back_out",    32'(outcome),         32'(0));

        // Last level cleared together with last life lost: WON
        level = 2'd3; pdot_exist = 1'b0; lives = 3'd0;
        tick();
        check("won_outcome", 32'(outcome), 32'(2));
        frames(30);
        at(168, 224);
        check("won_txt_dr",  32'(dr_out),  32'(1));
        check("won_txt_rgb", 32'(RGB_out), 32'(E_GREEN));
        at(160, 224);
        check("won_bg_rgb",  32'(RGB_out), 32'(E_GREY));
        at(168, 224);
        frames(29);
        check("blink_f29", 32'(RGB_out), 32'(E_GREEN));
        frame();
        check("blink_f30", 32'(RGB_out), 32'(E_GREY));
        frames(29);
        check("blink_f59", 32'(RGB_out), 32'(E_GREY));
        frame();
        check("blink_f60", 32'(RGB_out), 32'(E_GREEN));
        rs_cnt = 0;
        key_continue = 1'b1; tick(); key_continue = 1'b0;
        check("won_rs_hi", 32'(restart_req), 32'(1));
        tick();
        check("won_rs_cnt", 32'(rs_cnt), 32'(1));
        game_started = 1'b0;
        tick();
        check("won_idle",    32'(dut.u_fsm.state), 32'(S_IDLE));
        check("won_idle_oc", 32'(outcome),         32'(0));

        // Lost with auto-continue, no key
        game_started = 1'b1; pdot_exist = 1'b1; edot_exist = 1'b1;
        level = 2'd0; lives = 3'd3;
        tick();
        lives = 3'd0;
        tick();
        check("lost_outcome", 32'(outcome), 32'(3));
        frames(30);
        rs_cnt = 0; nl_cnt = 0;
        frames(299);
        check("auto_early", 32'(rs_cnt),           32'(0));
        check("auto_state", 32'(dut.u_fsm.state),  32'(S_SHOW));
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("auto_rs_hi", 32'(restart_req), 32'(1));
        tick();
        check("auto_rs_lo", 32'(restart_req),       32'(0));
        check("auto_exit",  32'(dut.u_fsm.state),   32'(S_EXIT));
        check("auto_nl",    32'(nl_cnt),            32'(0));
        game_started = 1'b0;
        tick();
        check("lost_idle",    32'(dut.u_fsm.state), 32'(S_IDLE));
        check("lost_idle_oc", 32'(outcome),         32'(0));

        // Abort during wipe, plus maze bounds
        game_started = 1'b1; lives = 3'd3;
        tick();
        lives = 3'd0;
        tick();
        frames(3);
        at(80, 10);
        check("bound_lo_out", 32'(dr_out), 32'(0));
        at(81, 10);
        check("bound_lo_in",  32'(dr_out), 32'(1));
        at(528, 10);
        check("bound_hi_out", 32'(dr_out), 32'(0));
        at(527, 10);
        check("bound_hi_in",  32'(dr_out), 32'(1));
        nl_cnt = 0; rs_cnt = 0;
        game_started = 1'b0;
        tick();
        check("abort_idle",   32'(dut.u_fsm.state), 32'(S_IDLE));
        check("abort_freeze", 32'(freeze_game),     32'(0));
        check("abort_oc",     32'(outcome),         32'(0));
        tick(); tick();
        check("abort_pulses", 32'(nl_cnt + rs_cnt), 32'(0));
        check("abort_dr",     32'(dr_out),          32'(0));

        // Asynchronous reset in the middle of SHOW
        game_started = 1'b1; lives = 3'd3;
        tick();
        lives = 3'd0;
        tick();
        frames(30);
        at(100, 100);
        check("pre_rst_dr", 32'(dr_out), 32'(1));
        resetN = 1'b0;
        #2;
        check("arst_dr",     32'(dr_out),           32'(0));
        check("arst_rgb",    32'(RGB_out),          32'(E_TRNS));
        check("arst_oc",     32'(outcome),          32'(0));
        check("arst_freeze", 32'(freeze_game),      32'(0));
        check("arst_state",  32'(dut.u_fsm.state),  32'(S_IDLE));
        tick(); tick(); tick();
        resetN = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
